// File: rtl/uart_tx_store_bridge_pkg.sv
// Shared definitions for the UART transmit store bridge.
// Holds the memory-mapped addresses, the TX FSM state encoding and a parity helper.
// Optional build macro: UART_TX_PARITY_EN (adds an even-parity bit to each frame).
package uart_tx_store_bridge_pkg;

    localparam logic [31:0] UART_TX_DATA_ADDR = 32'h8000_0008;
    localparam logic [31:0] UART_STATUS_ADDR  = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_store_bridge_tx_byte_fifo.sv
// Byte queue between the CPU store path and the UART transmitter.
// A push while full is still accepted when a pop happens in the same cycle,
// because the pop frees the slot being written.
module tx_byte_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg];

    // Storage array: written on accepted pushes, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_store_bridge.sv
// UART transmit bridge: queues CPU byte stores and serialises them 8N1, LSB first.
// The line output is registered, so it trails the FSM state by one cycle.
// Optional build macro: UART_TX_PARITY_EN (even-parity bit between data and stop).
module uart_tx_store_bridge #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         uart_we,
    input  logic [31:0]                  store_data,
    input  logic                         ovf_clr,
    output logic                         tx_ready,
    output logic                         tx_busy,
    output logic                         tx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         serial_out
);
    import uart_tx_store_bridge_pkg::*;

    localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
    localparam int BW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

    tx_state_t     state_reg, state_next;
    logic [BW-1:0] baud_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          serial_out_reg;
    logic          line_next;
    logic          overflow_reg;
    logic          bit_done;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          unused_store_bits;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg;
`endif

    assign unused_store_bits = ^store_data[31:8];
    assign bit_done          = (baud_cnt_reg == BW'(BIT_TICKS - 1));

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (uart_we),
        .push_data (store_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_ready    = !fifo_full;
    assign tx_busy     = (state_reg != ST_IDLE) || !fifo_empty;
    assign tx_overflow = overflow_reg;
    assign serial_out  = serial_out_reg;

    // Next-state and line level for the frame sequencer.
    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        line_next  = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                line_next = 1'b0;
                if (bit_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                line_next = shift_reg[0];
                if (bit_done && bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                line_next = parity_reg;
                if (bit_done) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and registered line driver; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            serial_out_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            serial_out_reg <= line_next;
        end
    end

    // Baud counter: held at zero while idle, restarts at every bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE || bit_done) begin
            baud_cnt_reg <= '0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    // Shift register loads the FIFO head on pop and shifts out one bit per bit time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else if (fifo_pop) begin
            shift_reg   <= fifo_head;
            bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= even_parity(fifo_head);
`endif
        end else if (state_reg == ST_DATA && bit_done) begin
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
        end
    end

    // Sticky overflow: a dropped store sets it and wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (uart_we && fifo_full && !fifo_pop) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

endmodule

// File: doc/uart_tx_store_bridge.md
Name: uart_tx_store_bridge

Overview:
Consumes the UART store strobe and byte lane produced by the store-path write controller (store to 0x80000008) and queues bytes in a small FIFO. A UART transmit FSM then serialises them 8N1, LSB first, onto the board TX pin. A status read path reports whether the CPU may store another byte, for the UART control/status register read mux.

Parameters:
CLOCK_FREQ, 50000000, core clock in Hz
BAUD_RATE, 115200, serial bit rate
FIFO_DEPTH, 8, TX byte queue entries; power of two, >= 2

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
uart_we  input  1  one-cycle store strobe (store to 0x80000008)
store_data  input  32  aligned store data; byte taken from [7:0]
ovf_clr  input  1  pulse; clears overflow flag
tx_ready  output  1  FIFO not full; CPU may store
tx_busy  output  1  FIFO non-empty or frame in flight
tx_overflow  output  1  sticky: store dropped while full
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
serial_out  output  1  UART TX line, idle high

Behaviour:
- Reset (async assert, sync-safe deassert by system): serial_out=1, tx_ready=1, tx_busy=0, tx_overflow=0, fifo_count=0, FSM=IDLE, pointers and baud counter 0.
- BIT_TICKS = CLOCK_FREQ/BAUD_RATE, integer-truncated; baud counter width $clog2(BIT_TICKS).
- FIFO: write pointer, read pointer, count. Write on uart_we && !full; store_data[7:0] captured at that edge. uart_we && full: byte dropped, tx_overflow set next cycle. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: both occur; count unchanged. Legal when full, because the pop frees the slot the same cycle, so the write is accepted and no overflow.
- tx_ready = (count != FIFO_DEPTH), combinational from count.
- ovf_clr and an overflow event in the same cycle: set wins.
- FSM states:
  - IDLE: serial_out=1. If count != 0, pop the head into shift register and go to START (1 cycle after data visible).
  - START: serial_out=0 for BIT_TICKS cycles, then DATA.
  - DATA: serial_out=shift[0] for BIT_TICKS cycles per bit; shift right; 8 bits, then PARITY (if enabled) else STOP.
  - STOP: serial_out=1 for BIT_TICKS cycles, then IDLE.
- Back-to-back frames: the IDLE visit costs exactly 1 cycle, so stop-to-next-start gap = 1 clk.
- tx_busy = (FSM != IDLE) || (count != 0).
- Latency: store at edge N; FIFO empty and IDLE -> serial_out falls at edge N+2.
- Reset mid-frame: line returns high immediately (async). FIFO contents discarded. No partial frame resumes.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: a PARITY state inserts one even-parity bit (XOR of the 8 data bits) between DATA and STOP, BIT_TICKS long. Frame = 11 bit-times.
- Undefined: no PARITY state, no parity logic. Frame = 10 bit-times.
- Ports identical in both builds.

Decomposition:
- Shared package/header (alongside the opcode/address definitions): UART TX data address 0x80000008, status address 0x80000000, FSM state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit).
- One sub-module: tx_byte_fifo (parameterised depth, 8-bit width; push/pop/full/empty/count).
- The FSM and baud counter stay in the top.

Test Plan:
(All with CLOCK_FREQ=1000, BAUD_RATE=100, so BIT_TICKS=10.)
- Single byte 0x55:
  - uart_we with store_data=0x00000055 -> serial_out low 10 cycles starting edge N+2.
  - Then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles.
  - tx_busy deasserts after the stop bit.
- Fill FIFO: 8 consecutive stores while the first frame is in flight.
  - tx_ready drops only once count reaches 8.
  - 9th store dropped -> tx_overflow=1, fifo_count stays 8.
  - ovf_clr pulse -> tx_overflow=0.
- Push and pop same cycle at full (count=8):
  - Store on the IDLE pop cycle -> accepted, count stays 8, no overflow.
  - All 9 bytes later appear on the line in order.
- Back-to-back 0xA5, 0x3C:
  - Second start bit begins exactly 1 cycle after the first stop bit ends.
  - Data bits LSB first, matching both bytes.
- Reset mid-frame: deassert rst_n during DATA bit 3 with 2 bytes queued.
  - serial_out=1 and fifo_count=0 without waiting for a clock edge.
  - No traffic after reset release.
- With UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 between bit 7 and stop; frame 110 cycles.
  - Without the macro, frame 100 cycles.
